// File: rtl/transf_buffer_ctrl.sv
// Input-device transfer buffer: a circular FIFO that feeds the CPU write-back mux,
// with a sticky underflow flag and a prioritised status code.
module transf_buffer_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         InData,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic                     Consume,
  input  logic                     IntAck,
  output logic [WIDTH-1:0]         TransfBuffer,
  output logic [2:0]               Interruption,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             underflow;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign push  = InValid && !full;
  assign pop   = Consume && !empty;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A set in the same cycle as an acknowledge must not be lost.
      if (Consume && empty)
        underflow <= 1'b1;
      else if (IntAck)
        underflow <= 1'b0;
    end
  end

  // Storage is never cleared; validity is defined only by pointers and count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= InData;
  end

  always_comb begin
    InReady      = !full;
    Count        = count;
    TransfBuffer = empty ? '0 : mem[rd_ptr];
    if (underflow)
      Interruption = 3'b100;
    else if (full)
      Interruption = 3'b010;
    else if (!empty)
      Interruption = 3'b001;
    else
      Interruption = 3'b000;
  end

endmodule

// File: doc/transf_buffer_ctrl.md
TRANSF_BUFFER_CTRL -- requirements
Module: transf_buffer_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered words; must be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 32, width of each data word.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 InData  in  WIDTH  word offered by the external input device.
REQ-006 InValid  in  1  device asserts that InData holds a valid word.
REQ-007 InReady  out  1  block can accept a word this cycle.
REQ-008 Consume  in  1  CPU write-back of the buffer word (MemToReg = 2'b11) occurs this cycle.
REQ-009 IntAck  in  1  CPU clears the sticky underflow flag.
REQ-010 TransfBuffer  out  WIDTH  head (oldest) buffered word, presented to the write-back mux.
REQ-011 Interruption  out  3  status code presented to the write-back mux.
REQ-012 Count  out  clog2(DEPTH)+1  number of words currently held.

Function
REQ-013 Storage SHALL be a circular FIFO of DEPTH words, with write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-014 InReady SHALL equal (Count != DEPTH); it is combinational from registered state only, with no dependence on InValid or Consume.
REQ-015 Push SHALL occur when InValid && InReady at a rising edge:
- InData is written at the write pointer.
- The write pointer increments.
REQ-016 When InValid is high and InReady is low, the word SHALL NOT be written. The device holds InData stable until the handshake completes. No data is lost and no error is flagged.
REQ-017 Pop SHALL occur when Consume && (Count != 0) at a rising edge; the read pointer increments.
REQ-018 Simultaneous push and pop SHALL both take effect, and Count SHALL be unchanged.
REQ-019 When full, InReady is low, so a Consume pop SHALL reduce Count to DEPTH-1. InReady rises the following cycle.
REQ-020 When empty, Consume SHALL NOT pop; it sets Underflow. A same-cycle push still completes. There is no bypass, so that word is not consumed.
REQ-021 Count SHALL update each cycle:
- +1 on push only.
- -1 on pop only.
- Unchanged otherwise.
- Count never exceeds DEPTH and never goes below 0.
REQ-022 TransfBuffer SHALL be the word at the read pointer when Count != 0, and all zeros when Count == 0. It is combinational from registered state.
REQ-023 Latency: a word pushed at edge N SHALL be visible on TransfBuffer after edge N when the FIFO was empty.
REQ-024 Underflow SHALL be a sticky register:
- Set by Consume while Count == 0.
- Cleared by IntAck.
- If set and clear occur in the same cycle, set wins.
REQ-025 Interruption SHALL be encoded with priority as follows:
- 3'b100 when Underflow is set.
- Else 3'b010 when Count == DEPTH.
- Else 3'b001 when Count != 0.
- Else 3'b000.
REQ-026 Stored word contents SHALL NOT be cleared on pop; only the pointers and the counter define validity.

Reset
REQ-027 When reset is high at an edge, the following SHALL be cleared to 0 regardless of any other input:
- Write pointer, read pointer, Count.
- Underflow.
A push or pop presented in the same cycle is discarded.
REQ-028 Outputs in the cycle after reset SHALL be: InReady = 1, Count = 0, TransfBuffer = 0, Interruption = 3'b000.
REQ-029 Reset asserted while the FIFO holds data SHALL discard all held words. Memory contents need not be cleared.

Verification
REQ-030 Single word:
- Stimulus: after reset, push 32'hDEADBEEF for one cycle.
- Response: next cycle Count = 1, TransfBuffer = 32'hDEADBEEF, Interruption = 3'b001.
- Then Consume for one cycle: Count = 0, TransfBuffer = 0, Interruption = 3'b000.
REQ-031 Fill and back-pressure:
- Stimulus: push 1, 2, 3, 4, then hold InValid with 5.
- Response: after the fourth push Count = 4, InReady = 0, Interruption = 3'b010; 5 is not accepted.
- Then Consume once: Count = 3; next cycle 5 is accepted; pops yield 2, 3, 4, 5 in order.
REQ-032 Wrap-around:
- Stimulus: 10 alternating push/pop cycles with values 100..109.
- Response: every pop returns its value in order; pointers wrap without loss.
REQ-033 Simultaneous push and pop:
- Stimulus: with Count = 2 holding A, B, push C with Consume in the same cycle.
- Response: Count stays 2; head becomes B; a later pop returns C.
REQ-034 Underflow:
- Stimulus: Consume while empty, together with a push of 7.
- Response: next cycle Interruption = 3'b100, Count = 1, TransfBuffer = 7.
- IntAck then Interruption = 3'b001.
- IntAck together with Consume on an empty FIFO leaves Interruption = 3'b100.
REQ-035 Reset mid-operation:
- Stimulus: reset asserted with Count = 3 and a push pending.
- Response: next cycle Count = 0, InReady = 1, Interruption = 3'b000, TransfBuffer = 0.
